// File: rtl/sec_tick_gen.sv
// sec_tick_gen: 1 Hz timebase for the alarm clock.
// Divides clk by CLK_HZ, keeps a BCD seconds count 00-59, and emits a
// one-cycle tick_1hz per second plus min_inc on every 59->00 rollover.
// Optional feature macro: SEC_BLINK_EN (drives blink as a 50% colon blink
// derived from the prescaler; without it blink is tied low).
//
// Handshake: tick_1hz and min_inc are valid-only strobes with no ready.
// Each is high for exactly one cycle and the consumer must act on the
// cycle it is high; min_inc is only ever high together with tick_1hz.
module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  output logic [3:0] sec_U,
  output logic [3:0] sec_T,
  output logic       tick_1hz,
  output logic       min_inc,
  output logic       blink
);

  localparam int            PW    = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PTERM = PW'(CLK_HZ - 1);

  logic [PW-1:0] pcnt;

  // Prescaler, BCD seconds and registered pulses; reset > clear > run > hold.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pcnt     <= '0;
      sec_U    <= 4'd0;
      sec_T    <= 4'd0;
      tick_1hz <= 1'b0;
      min_inc  <= 1'b0;
    end else begin
      // Pulses default low so they can never stretch past one cycle.
      tick_1hz <= 1'b0;
      min_inc  <= 1'b0;
      if (run) begin
        if (pcnt == PTERM) begin
          pcnt     <= '0;
          tick_1hz <= 1'b1;
          if (sec_U == 4'd9) begin
            sec_U <= 4'd0;
            if (sec_T == 4'd5) begin
              sec_T   <= 4'd0;
              min_inc <= 1'b1;
            end else begin
              sec_T <= sec_T + 4'd1;
            end
          end else begin
            sec_U <= sec_U + 4'd1;
          end
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end
    end
  end

`ifdef SEC_BLINK_EN
  // CLK_HZ/2 never exceeds CLK_HZ-1, so it always fits in the prescaler width.
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  // Colon on for the first half of each second; follows the registered pcnt.
  always_comb begin
    blink = (pcnt < HALF);
  end
`else
  // Blink feature absent: constant low, no comparator.
  always_comb begin
    blink = 1'b0;
  end
`endif

endmodule

// File: tb/tb_sec_tick_gen.sv
// tb_sec_tick_gen: directed bench for sec_tick_gen with CLK_HZ=4.
// The driver pushes each expected tick (cycle stamp, seconds, min_inc)
// into exp_q; the monitor pops one entry whenever tick_1hz is high.
module tb_sec_tick_gen;

  localparam int CLK_HZ = 4;
  localparam int W      = 25;  // {stamp[15:0], sec_T, sec_U, min_inc}

`ifdef SEC_BLINK_EN
  localparam logic BLINK_HI = 1'b1;
`else
  localparam logic BLINK_HI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       clear;
  logic [3:0] sec_U;
  logic [3:0] sec_T;
  logic       tick_1hz;
  logic       min_inc;
  logic       blink;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] exp_q[$];

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .clear    (clear),
    .sec_U    (sec_U),
    .sec_T    (sec_T),
    .tick_1hz (tick_1hz),
    .min_inc  (min_inc),
    .blink    (blink)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tick(input int stamp, input int sec);
    exp_q.push_back({16'(stamp), 4'(sec / 10), 4'(sec % 10), (sec == 0)});
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero_state(input string name);
    check({name, "_sec"}, {sec_T, sec_U}, 8'h00);
    check({name, "_tick"}, {7'd0, tick_1hz}, 8'd0);
    check({name, "_min"}, {7'd0, min_inc}, 8'd0);
  endtask

  // Monitor / scoreboard
  logic [W-1:0] exp_e;
  logic [W-1:0] act_e;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (min_inc && !tick_1hz) begin
        errors++;
        $display("FAIL min_inc_alone: min_inc=1 tick_1hz=0 at cycle %0d", cyc);
      end
      if (tick_1hz) begin
        checks++;
        act_e = {16'(cyc), sec_T, sec_U, min_inc};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: got %h with nothing expected", act_e);
        end else begin
          exp_e = exp_q.pop_front();
          if (act_e !== exp_e) begin
            errors++;
            $display("FAIL tick: got cyc=%0d sec=%h%h min=%b expected cyc=%0d sec=%h%h min=%b",
                     act_e[24:9], act_e[8:5], act_e[4:1], act_e[0],
                     exp_e[24:9], exp_e[8:5], exp_e[4:1], exp_e[0]);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int e;
    reset = 1'b1;
    run   = 1'b1;
    clear = 1'b0;

    // Reset held two cycles with run high
    step(2);
    check_zero_state("reset");
    check("reset_blink", {7'd0, blink}, {7'd0, BLINK_HI});
    mon_en = 1'b1;
    reset  = 1'b0;

    // Count and two minute rollovers: tick every 4 edges, 00 at 240 and 480
    e = cyc;
    for (int k = 1; k <= 120; k++) push_tick(e + 4 * k, k % 60);
    step(480);

    // Advance to seconds 37 with pcnt=2
    e = cyc;
    for (int k = 1; k <= 37; k++) push_tick(e + 4 * k, k);
    step(150);
    check("pre_clear_sec", {sec_T, sec_U}, 8'h37);
    check("pre_clear_blink", {7'd0, blink}, 8'd0);

    // One-cycle clear mid-count
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_zero_state("clear_mid");
    check("clear_blink", {7'd0, blink}, {7'd0, BLINK_HI});

    // Restart from 00: first tick 4 edges later, run on to seconds 12, pcnt=1
    e = cyc;
    for (int k = 1; k <= 12; k++) push_tick(e + 4 * k, k);
    step(49);
    check("pre_pause_sec", {sec_T, sec_U}, 8'h12);

    // Pause ten cycles: everything frozen, no pulses
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("pause_sec", {sec_T, sec_U}, 8'h12);
      check("pause_tick", {7'd0, tick_1hz}, 8'd0);
      check("pause_blink", {7'd0, blink}, {7'd0, BLINK_HI});
    end
    run = 1'b1;
    e = cyc;
    push_tick(e + 3, 13);
    step(3);
    check("resume_sec", {sec_T, sec_U}, 8'h13);

    // Advance to 59 with pcnt=3, then clear on the rollover edge
    e = cyc;
    for (int k = 1; k <= 46; k++) push_tick(e + 4 * k, 13 + k);
    step(187);
    check("pre_clr59_sec", {sec_T, sec_U}, 8'h59);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_zero_state("clear_roll");

    // Again to 59 with pcnt=3, then reset on the rollover edge
    e = cyc;
    for (int k = 1; k <= 59; k++) push_tick(e + 4 * k, k);
    step(239);
    check("pre_rst59_sec", {sec_T, sec_U}, 8'h59);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_zero_state("reset_roll");

    // Counting resumes normally after reset
    e = cyc;
    push_tick(e + 4, 1);
    step(5);
    check("post_reset_sec", {sec_T, sec_U}, 8'h01);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
